// File: rtl/rf_2p_reader_pkg.sv
// Shared types for the RF_2P burst read path: reader FSM states and skid depth.
package RFCfg;

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} RdState;

    localparam int unsigned RD_SKID_DEPTH = 2;

endpackage

// File: rtl/rf_2p_reader_skid.sv
// rf_rd_skid: two-entry FIFO of {data, last} that absorbs RF read data so that
// backpressure on the output stream never loses a word already in flight.
module rf_rd_skid
    import RFCfg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic [1:0]   count_o
);

    logic [W:0] mem_q [RD_SKID_DEPTH];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;

    // One-bit pointers are sufficient because the depth is fixed at two entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RD_SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= {data_i, last_i};
                wr_q        <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_q][W:1];
    assign last_o  = valid_o && mem_q[rd_q][0];
    assign count_o = cnt_q;

endmodule

// File: rtl/rf_2p_reader.sv
// rf_2p_reader: burst read engine for RF_2P macros with address wrap at WORDWD and a
// lossless valid/ready output stream. Define RF_RD_CONFLICT_CHK_EN to withhold reads colliding with a monitored write.
module rf_2p_reader
    import RFCfg::*;
#(
    parameter int unsigned WORDWD = 12,
    parameter int unsigned DWD    = 16,
    parameter int unsigned AWD    = $clog2(WORDWD),
    parameter int unsigned SIZE   = 1,
    parameter int unsigned LENWD  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [AWD-1:0]            i_base,
    input  logic [LENWD-1:0]          i_len,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_read,
    output logic [AWD-1:0]            o_raddr,
    input  logic [SIZE-1:0][DWD-1:0]  i_rdata,
    input  logic                      i_wmon,
    input  logic [AWD-1:0]            i_wmon_addr,
    output logic                      o_dval,
    input  logic                      i_dack,
    output logic [SIZE-1:0][DWD-1:0]  o_data,
    output logic                      o_last
);

    RdState           state_q, state_d;
    logic [AWD-1:0]   addr_q, addr_d;
    logic [LENWD-1:0] issue_q, issue_d;
    logic [LENWD-1:0] deliver_q, deliver_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             inflight_q;
    logic             inflight_last_q;

    logic             read;
    logic             pop;
    logic             conflict;
    logic             credit_ok;
    logic             burst_end;
    logic             head_valid;
    logic             head_last;
    logic [1:0]       occ;

`ifdef RF_RD_CONFLICT_CHK_EN
    assign conflict = i_wmon && (i_wmon_addr == addr_q);
`else
    logic unused_wmon;
    assign unused_wmon = i_wmon ^ (^i_wmon_addr);
    assign conflict    = 1'b0;
`endif

    assign pop       = head_valid && i_dack;
    // Occupancy plus the word in flight may never exceed the two skid entries.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign burst_end = (state_q == RD_DRAIN) && pop && (deliver_q == LENWD'(1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        issue_d   = issue_q;
        deliver_d = deliver_q;
        done_d    = 1'b0;
        read      = 1'b0;

        if (pop && (deliver_q != '0)) begin
            deliver_d = deliver_q - LENWD'(1);
        end

        case (state_q)
            RD_IDLE: begin
                if (i_start && !busy_q) begin
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d    = i_base;
                        issue_d   = i_len;
                        deliver_d = i_len;
                        state_d   = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (credit_ok && !conflict) begin
                    read    = 1'b1;
                    addr_d  = (addr_q == AWD'(WORDWD - 1)) ? '0 : addr_q + AWD'(1);
                    issue_d = issue_q - LENWD'(1);
                    if (issue_q == LENWD'(1)) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (burst_end) begin
                    done_d  = 1'b1;
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase

        // Busy stays high through the cycle that carries the done pulse.
        busy_d = (state_d != RD_IDLE) || burst_end;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= RD_IDLE;
            addr_q          <= '0;
            issue_q         <= '0;
            deliver_q       <= '0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            issue_q         <= issue_d;
            deliver_q       <= deliver_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            inflight_q      <= read;
            inflight_last_q <= read && (issue_q == LENWD'(1));
        end
    end

    rf_rd_skid #(
        .W (SIZE * DWD)
    ) u_skid (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (inflight_q),
        .data_i  (i_rdata),
        .last_i  (inflight_last_q),
        .pop_i   (pop),
        .valid_o (head_valid),
        .data_o  (o_data),
        .last_o  (head_last),
        .count_o (occ)
    );

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_read  = read;
    assign o_raddr = addr_q;
    assign o_dval  = head_valid;
    assign o_last  = head_last;

endmodule
